// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
//   mem_src_e            : identifies which requester issued a transaction.
//   ARB_DEFAULT_DEPTH    : default response-routing FIFO depth (max outstanding).
//   ARB_DEFAULT_STARVE   : default number of lost cycles before a fetch wins.
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } mem_src_e;

    localparam int unsigned ARB_DEFAULT_DEPTH  = 2;
    localparam int unsigned ARB_DEFAULT_STARVE = 4;

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of requester ids, one entry per accepted memory transaction.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (clears to empty)
//   push_i, src_i  : enqueue src_i (ignored when full)
//   pop_i          : dequeue head (ignored when empty)
//   full_o/empty_o : occupancy flags
//   head_o         : id of the oldest outstanding transaction
module resp_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ARB_DEFAULT_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     push_i,
    input  mem_src_e src_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output mem_src_e head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mem_src_e        slot_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = slot_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SRC_INSTR;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                slot_q[wr_ptr_q] <= src_i;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   instr_*                  : fetch port (req/addr in, gnt/rvalid/rdata out)
//   data_*                   : load/store port (req/addr/we/be/wdata in, gnt/rvalid/rdata out)
//   mem_*                    : shared memory port (req/addr/we/be/wdata out, gnt/rvalid/rdata in)
// Data has priority unless a fetch has lost STARVE_LIMIT consecutive cycles.
// A presented but ungranted request is locked until accepted. Responses are
// routed back in order through a FIFO of requester ids.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = ARB_DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT    = ARB_DEFAULT_STARVE
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    mem_src_e        win_src;
    mem_src_e        lock_src_q, lock_src_d;
    mem_src_e        head_src;
    logic            lock_q, lock_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            win_req, mem_hs, instr_hs, rsp_pop;
    logic            fifo_full, fifo_empty;

    always_comb begin
        if (lock_q)                                             win_src = lock_src_q;
        else if (data_req_i && (starve_q < SW'(STARVE_LIMIT)))  win_src = SRC_DATA;
        else if (instr_req_i)                                   win_src = SRC_INSTR;
        else                                                    win_src = SRC_DATA;
    end

    always_comb begin
        win_req     = (win_src == SRC_DATA) ? data_req_i : instr_req_i;
        // No push-through: a full FIFO blocks requests even if it pops this cycle.
        mem_req_o   = rst_n_i && win_req && !fifo_full;
        mem_hs      = mem_req_o && mem_gnt_i;
        instr_hs    = mem_hs && (win_src == SRC_INSTR);
        instr_gnt_o = instr_hs;
        data_gnt_o  = mem_hs && (win_src == SRC_DATA);

        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (win_src == SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end

        rsp_pop        = rst_n_i && mem_rvalid_i && !fifo_empty;
        instr_rvalid_o = rsp_pop && (head_src == SRC_INSTR);
        data_rvalid_o  = rsp_pop && (head_src == SRC_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
    end

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (mem_hs) begin
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = win_src;
        end

        starve_d = starve_q;
        if (!instr_req_i || instr_hs) begin
            starve_d = '0;
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            starve_q   <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            starve_q   <= starve_d;
        end
    end

    resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (mem_hs),
        .src_i   (win_src),
        .pop_i   (rsp_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_src)
    );

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(mem_rvalid_i && fifo_empty)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAXO = 2;
    localparam int LIM  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: outstanding ids as a queue (1 = data, 0 = fetch),
    // a "stuck request" flag with its owner, and a count of consecutive fetch losses.
    bit q[$];
    bit m_stuck;
    bit m_owner;
    int m_lost;

    always @(negedge clk) begin
        bit w, wreq, ereq, hs, pop, head;
        if (!rst_n) begin
            q.delete();
            m_stuck = 0;
            m_owner = 0;
            m_lost  = 0;
            chk("m_rst_req", 32'(mem_req_o), 0);
            chk("m_rst_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 0);
            chk("m_rst_rv",  {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
        end else begin
            if (m_stuck)                        w = m_owner;
            else if (data_req_i && m_lost < LIM) w = 1;
            else if (instr_req_i)               w = 0;
            else                                w = 1;
            wreq = w ? data_req_i : instr_req_i;
            ereq = wreq && (q.size() < MAXO);
            hs   = ereq && mem_gnt_i;
            pop  = mem_rvalid_i && (q.size() > 0);
            head = (q.size() > 0) ? q[0] : 1'b0;

            chk("m_req",   32'(mem_req_o),   32'(ereq));
            chk("m_igt",   32'(instr_gnt_o), 32'(hs && !w));
            chk("m_dgt",   32'(data_gnt_o),  32'(hs && w));
            chk("m_irv",   32'(instr_rvalid_o), 32'(pop && !head));
            chk("m_drv",   32'(data_rvalid_o),  32'(pop && head));
            if (ereq) begin
                chk("m_addr",  mem_addr_o,       w ? data_addr_i : instr_addr_i);
                chk("m_we",    32'(mem_we_o),    w ? 32'(data_we_i) : 0);
                chk("m_be",    32'(mem_be_o),    w ? 32'(data_be_i) : 32'hF);
                chk("m_wdata", mem_wdata_o,      w ? data_wdata_i : 0);
            end
            if (pop) begin
                chk("m_rdata", head ? data_rdata_o : instr_rdata_o, mem_rdata_i);
            end

            if (pop) void'(q.pop_front());
            if (hs) q.push_back(w);
            if (hs) m_stuck = 0;
            else if (ereq) begin
                m_stuck = 1;
                m_owner = w;
            end
            if (!instr_req_i || (hs && !w)) m_lost = 0;
            else if (m_lost < LIM)          m_lost++;
        end
    end

    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                       input logic g, input logic rv, input logic [31:0] rd);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwd;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drv(1, 32'h3000, 1, 32'h100, 0, 4'hF, 0, 1, 1, 0);
        nxt;
        #2;
        chk("rst_req",  32'(mem_req_o), 0);
        chk("rst_dgnt", 32'(data_gnt_o), 0);
        chk("rst_drv",  32'(data_rvalid_o), 0);
        nxt;

        // Idle
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #2;
        chk("idle_req", 32'(mem_req_o), 0);
        chk("idle_irv", 32'(instr_rvalid_o), 0);
        nxt;

        // Simultaneous requests: data first, fetch next
        drv(1, 32'h3000, 1, 32'h100, 0, 4'hF, 0, 1, 0, 0);
        #2;
        chk("sim_dgnt", 32'(data_gnt_o), 1);
        chk("sim_igt0", 32'(instr_gnt_o), 0);
        chk("sim_addr0", mem_addr_o, 32'h100);
        nxt;
        drv(1, 32'h3000, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        #2;
        chk("sim_igt1",  32'(instr_gnt_o), 1);
        chk("sim_addr1", mem_addr_o, 32'h3000);
        nxt;

        // Responses routed back in issue order
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF);
        #2;
        chk("rsp_drv",   32'(data_rvalid_o), 1);
        chk("rsp_irv0",  32'(instr_rvalid_o), 0);
        chk("rsp_drd",   data_rdata_o, 32'hDEADBEEF);
        nxt;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h13);
        #2;
        chk("rsp_irv",   32'(instr_rvalid_o), 1);
        chk("rsp_drv0",  32'(data_rvalid_o), 0);
        chk("rsp_ird",   instr_rdata_o, 32'h13);
        nxt;

        // Stall: data store held by the memory for three cycles
        for (int k = 0; k < 3; k++) begin
            drv(1, 32'h3000, 1, 32'h100, 1, 4'h3, 32'hCAFE, 0, 0, 0);
            #2;
            chk("stall_req",  32'(mem_req_o), 1);
            chk("stall_addr", mem_addr_o, 32'h100);
            chk("stall_igt",  32'(instr_gnt_o), 0);
            nxt;
        end
        drv(1, 32'h3000, 1, 32'h100, 1, 4'h3, 32'hCAFE, 1, 0, 0);
        #2;
        chk("stall_dgnt", 32'(data_gnt_o), 1);
        chk("stall_we",   32'(mem_we_o), 1);
        nxt;
        drv(1, 32'h3000, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        #2;
        chk("fetch_igt", 32'(instr_gnt_o), 1);
        chk("fetch_be",  32'(mem_be_o), 32'hF);
        chk("fetch_we",  32'(mem_we_o), 0);
        nxt;

        // FIFO full: blocked even with a same-cycle response
        drv(1, 32'h3004, 0, 0, 0, 4'h0, 0, 1, 1, 32'h11);
        #2;
        chk("full_req", 32'(mem_req_o), 0);
        chk("full_igt", 32'(instr_gnt_o), 0);
        chk("full_drv", 32'(data_rvalid_o), 1);
        nxt;
        drv(1, 32'h3004, 0, 0, 0, 4'h0, 0, 1, 1, 32'h22);
        #2;
        chk("refill_req",  32'(mem_req_o), 1);
        chk("refill_igt",  32'(instr_gnt_o), 1);
        chk("refill_addr", mem_addr_o, 32'h3004);
        chk("refill_irv",  32'(instr_rvalid_o), 1);
        nxt;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 32'h33);
        #2;
        chk("drain_irv", 32'(instr_rvalid_o), 1);
        nxt;

        // Starvation guard: fetch wins after four lost cycles
        for (int k = 0; k < 7; k++) begin
            drv(k <= 4, 32'h4000, k <= 5, (k <= 5) ? ((k < 4) ? 32'h200 + 32'(4 * k) : 32'h210) : 0,
                0, 4'hF, 0, 1, k >= 1, 32'h1000 + 32'(k));
            #2;
            if (k < 4 || k == 5) chk("starve_dgnt", 32'(data_gnt_o), 1);
            if (k == 4) begin
                chk("starve_igt",  32'(instr_gnt_o), 1);
                chk("starve_dgnt0", 32'(data_gnt_o), 0);
                chk("starve_addr", mem_addr_o, 32'h4000);
            end
            if (k == 5) chk("starve_irv", 32'(instr_rvalid_o), 1);
            nxt;
        end

        // Asynchronous reset in the middle of a stalled fetch
        drv(0, 0, 1, 32'h300, 0, 4'hF, 0, 1, 0, 0);
        nxt;
        drv(1, 32'h5000, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        nxt;
        drv(1, 32'h5000, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req_o), 0);
        chk("arst_igt", 32'(instr_gnt_o), 0);
        chk("arst_drv", 32'(data_rvalid_o), 0);
        nxt;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        nxt;
        drv(1, 32'h5000, 0, 0, 0, 4'h0, 0, 1, 0, 0);
        rst_n = 1'b1;
        #2;
        chk("post_igt",  32'(instr_gnt_o), 1);
        chk("post_addr", mem_addr_o, 32'h5000);
        nxt;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h55);
        #2;
        chk("post_irv", 32'(instr_rvalid_o), 1);
        chk("post_ird", instr_rdata_o, 32'h55);
        nxt;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        nxt;
        nxt;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one unified single-port memory between the core's instruction-fetch and data-access interfaces.
- Used by the FPGA/SoC top and by formal harnesses that model a single memory behind a req/gnt/rvalid handshake.
- Data accesses have priority over instruction fetches, with a starvation guard for fetches.
- An in-order response-routing FIFO returns each rvalid to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory transactions (response FIFO depth, ≥1).
- STARVE_LIMIT, 4, consecutive cycles a pending instruction request may lose before it wins priority (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch accepted this cycle.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  32  fetch data.
- data_req_i  in  1  load/store request.
- data_addr_i  in  32  data byte address.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  data accepted this cycle.
- data_rvalid_o  out  1  load data / store acknowledge valid.
- data_rdata_o  out  32  load data.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  32  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_wdata_o  out  32  memory write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory response data.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_n_i.
- Reset state:
  - All registered state cleared: FIFO empty, lock clear, starve counter 0.
  - mem_req_o, both gnt_o and both rvalid_o are 0 while rst_n_i = 0.
- Handshake (per port): a transfer occurs on a cycle with req & gnt. Requester holds req and all attributes stable until gnt.
- Selection (combinational):
  - If lock is set, the locked source wins.
  - Else if data_req_i and starve count < STARVE_LIMIT, DATA wins.
  - Else if instr_req_i, INSTR wins.
  - Else if data_req_i, DATA wins.
- Memory request: mem_req_o = winner's req & !fifo_full. mem_addr/we/be/wdata are muxed from the winner.
  - For INSTR: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- Grant routing: winner's gnt_o = mem_gnt_i & mem_req_o. Loser's gnt_o = 0. Zero-cycle gnt path allowed.
- Lock:
  - Set when mem_req_o = 1 & mem_gnt_i = 0; holds the current winner, so a presented request is never withdrawn or switched.
  - Cleared on the handshake.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle instr_req_i = 1 and INSTR is not granted.
  - Cleared on instr handshake, or when instr_req_i = 0.
- Response FIFO:
  - Pushes winner id on every mem handshake; pops on mem_rvalid_i.
  - Full when MAX_OUTSTANDING entries are held. When full, mem_req_o = 0 even if a pop occurs the same cycle (no push-through).
  - Push and pop in the same cycle while not full: count unchanged, ordering preserved, pointers wrap modulo depth.
- Response routing:
  - On mem_rvalid_i, head id selects the target: that port's rvalid_o = 1. rdata_o = mem_rdata_i on both ports (data valid only with rvalid).
  - Zero-latency combinational path.
- mem_rvalid_i with empty FIFO: protocol error. Both rvalid_o = 0, no state change. Covered by a simulation assertion.
- Responses are strictly in order. A response may arrive the cycle after gnt at the earliest.
- Reset mid-operation: outstanding transactions are dropped. The memory model is reset together with the arbiter.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} mem_src_e.
  - Localparam default depth.
- Sub-module resp_id_fifo:
  - Parameterised depth, 1-bit payload (mem_src_e).
  - Outputs full/empty/head; synchronous push/pop; async active-low reset.

Test Plan:
- Idle after reset: no requests -> mem_req_o = 0, all gnt/rvalid 0, FIFO empty.
- Simultaneous req, instr_addr = 0x3000, data_addr = 0x100, mem_gnt_i = 1 -> data granted first, mem_addr_o = 0x100; instr granted next cycle with mem_addr_o = 0x3000.
- Stall then grant: mem_gnt_i held 0 for 3 cycles while both requesting, data winning -> mem_addr_o stays 0x100 for all 3 cycles (lock), instr not granted.
- Starvation: data_req continuous, instr_req continuous, mem_gnt_i = 1 -> instr granted after 4 losing cycles (STARVE_LIMIT = 4), then data resumes.
- Out-of-port responses: grant data then instr, mem_rvalid_i on two later cycles with rdata 0xDEADBEEF then 0x00000013 -> data_rvalid_o with 0xDEADBEEF, then instr_rvalid_o with 0x00000013.
- FIFO full: two grants with no rvalid -> mem_req_o = 0 on the third request even with a same-cycle rvalid; reasserts the following cycle. Async reset mid-transfer -> outputs 0 immediately.
